// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 fetch constants: instruction codes, status
//               codes, the "no register" specifier and the fetch FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Instruction codes (byte0[7:4])
  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  // Status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Register specifier meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // Fetch FSM states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BYTE0 = 3'd1,
    S_REGS  = 3'd2,
    S_CONST = 3'd3,
    S_DONE  = 3'd4
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_len_dec.sv
`default_nettype none
// ============================================================================
// Module      : fetch_len_dec
// Description : Combinational instruction-length decoder. Maps an icode to
//               its byte length and whether a register byte and/or an 8-byte
//               constant follow. Unknown icodes report length 1, invalid.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_len_dec
  import y86_pkg::*;
(
  input  logic [3:0] i_icode,
  output logic [3:0] o_len,
  output logic       o_need_regs,
  output logic       o_need_valc,
  output logic       o_instr_valid
);

  // Length/format lookup; the default covers the 1-byte formats
  always_comb begin
    o_len         = 4'd1;
    o_need_regs   = 1'b0;
    o_need_valc   = 1'b0;
    o_instr_valid = 1'b1;
    case (i_icode)
      ICODE_HALT, ICODE_NOP, ICODE_RET: begin
        o_len = 4'd1;
      end
      ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: begin
        o_len       = 4'd2;
        o_need_regs = 1'b1;
      end
      ICODE_JXX, ICODE_CALL: begin
        o_len       = 4'd9;
        o_need_valc = 1'b1;
      end
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ: begin
        o_len       = 4'd10;
        o_need_regs = 1'b1;
        o_need_valc = 1'b1;
      end
      default: begin
        o_instr_valid = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Y86-64 sequential fetch unit. Reads an instruction one byte
//               at a time over a req/ack memory port, assembles the decoded
//               fields and presents them on a valid/ready output port.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import y86_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int IMEM_SIZE = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [63:0]       valC,
  output logic [ADDR_W-1:0] valP,
  output logic [2:0]        stat
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_valp;
  logic [3:0]        r_cnt;
  logic [3:0]        r_icode;
  logic [3:0]        r_ifun;
  logic [3:0]        r_ra;
  logic [3:0]        r_rb;
  logic [63:0]       r_valc;
  logic [2:0]        r_stat;

  logic              w_req_state;
  logic              w_in_range;
  logic              w_take;
  logic              w_fault;
  logic              w_last;
  logic [3:0]        w_dec_icode;
  logic [3:0]        w_len;
  logic              w_need_regs;
  logic              w_need_valc;
  logic              w_instr_valid;
  logic [2:0]        w_kidx;

  assign w_req_state = (r_state == S_BYTE0) || (r_state == S_REGS) || (r_state == S_CONST);
  assign w_in_range  = (r_addr < ADDR_W'(IMEM_SIZE));
  // A good byte arrives this cycle
  assign w_take      = w_req_state & w_in_range & mem_ack & ~mem_err;
  // Either the address is illegal (no request is made) or the access faulted
  assign w_fault     = w_req_state & (~w_in_range | (mem_ack & mem_err));
  // While byte0 is arriving, decode it straight off the bus so length is known
  assign w_dec_icode = (r_state == S_BYTE0) ? mem_rdata[7:4] : r_icode;
  assign w_last      = (r_cnt == (w_len - 4'd1));
  // Constant byte index = bytes consumed minus the opcode (and register) byte
  assign w_kidx      = 3'(r_cnt - (w_need_regs ? 4'd2 : 4'd1));

  fetch_len_dec u_len_dec (
    .i_icode       (w_dec_icode),
    .o_len         (w_len),
    .o_need_regs   (w_need_regs),
    .o_need_valc   (w_need_valc),
    .o_instr_valid (w_instr_valid)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state selection and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    mem_req     = w_req_state & w_in_range;
    out_valid   = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_BYTE0;
      end
      S_BYTE0: begin
        if (w_fault) begin
          w_state_nxt = S_DONE;
        end else if (w_take) begin
          if (!w_instr_valid || (w_len == 4'd1)) w_state_nxt = S_DONE;
          else if (w_need_regs)                  w_state_nxt = S_REGS;
          else                                   w_state_nxt = S_CONST;
        end
      end
      S_REGS: begin
        if (w_fault)     w_state_nxt = S_DONE;
        else if (w_take) w_state_nxt = w_need_valc ? S_CONST : S_DONE;
      end
      S_CONST: begin
        if (w_fault)               w_state_nxt = S_DONE;
        else if (w_take && w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address/base registers, byte counter and field assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_base  <= '0;
      r_valp  <= '0;
      r_cnt   <= 4'd0;
      r_icode <= 4'h0;
      r_ifun  <= 4'h0;
      r_ra    <= RNONE;
      r_rb    <= RNONE;
      r_valc  <= 64'd0;
      r_stat  <= STAT_AOK;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        // Fresh defaults; valP assumes the default (halt, 1-byte) length
        // so a fault on byte0 still reports base + 1.
        r_addr  <= pc;
        r_base  <= pc;
        r_valp  <= pc + ADDR_W'(1);
        r_cnt   <= 4'd0;
        r_icode <= 4'h0;
        r_ifun  <= 4'h0;
        r_ra    <= RNONE;
        r_rb    <= RNONE;
        r_valc  <= 64'd0;
        r_stat  <= STAT_AOK;
      end
    end else if (w_fault) begin
      r_stat <= STAT_ADR;
    end else if (w_take) begin
      r_addr <= r_addr + ADDR_W'(1);
      r_cnt  <= r_cnt + 4'd1;
      case (r_state)
        S_BYTE0: begin
          r_icode <= mem_rdata[7:4];
          r_ifun  <= mem_rdata[3:0];
          r_valp  <= r_base + ADDR_W'(w_len);
          if (!w_instr_valid)                 r_stat <= STAT_INS;
          else if (mem_rdata[7:4] == ICODE_HALT) r_stat <= STAT_HLT;
        end
        S_REGS: begin
          r_ra <= mem_rdata[7:4];
          r_rb <= mem_rdata[3:0];
        end
        S_CONST: begin
          r_valc[{w_kidx, 3'b000} +: 8] <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = r_addr;
  assign icode    = r_icode;
  assign ifun     = r_ifun;
  assign rA       = r_ra;
  assign rB       = r_rb;
  assign valC     = r_valc;
  assign valP     = r_valp;
  assign stat     = r_stat;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed instruction
//               cases, address faults, randomized memory latency with output
//               back-pressure, and reset in the middle of a fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam int ADDR_W    = 64;
  localparam int IMEM_SIZE = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              mem_err;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        icode, ifun, rA, rB;
  logic [63:0]       valC;
  logic [ADDR_W-1:0] valP;
  logic [2:0]        stat;

  fetch_stage #(.ADDR_W(ADDR_W), .IMEM_SIZE(IMEM_SIZE)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .out_valid(out_valid),
    .out_ready(out_ready), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .stat(stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [2:0]  stat;
    int          acks;
  } fetch_t;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mem [0:IMEM_SIZE-1];
  logic [63:0] err_addr  = '1;
  int          max_delay = 0;
  bit          mem_auto  = 1'b1;
  int          ack_count = 0;
  int          bad_hold  = 0;
  int          bad_range = 0;

  // Memory responder and port monitor, acting on the falling edge
  initial begin
    int          wait_cnt;
    int          cur_delay;
    bit          pending;
    logic [63:0] prev_addr;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 8'h00;
    wait_cnt = 0; cur_delay = 0; pending = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (mem_auto) begin mem_ack = 1'b0; mem_err = 1'b0; end
      if (mem_req && (mem_addr >= 64'(IMEM_SIZE))) bad_range++;
      if (pending && mem_req && (mem_addr !== prev_addr)) bad_hold++;
      pending = 1'b0;
      if (mem_auto && mem_req && !rst) begin
        if (wait_cnt >= cur_delay || wait_cnt >= max_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr[11:0]];
          mem_err   = (mem_addr == err_addr);
          ack_count++;
          wait_cnt  = 0;
          cur_delay = int'($urandom_range(max_delay));
        end else begin
          wait_cnt++;
          pending   = 1'b1;
          prev_addr = mem_addr;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [146:0] pack(fetch_t e);
    return {e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.stat};
  endfunction

  function automatic fetch_t mk(logic [3:0] ic, logic [3:0] fn, logic [3:0] ra, logic [3:0] rb,
                                logic [63:0] vc, logic [63:0] vp, logic [2:0] st);
    fetch_t e;
    e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
    e.valc = vc; e.valp = vp; e.stat = st; e.acks = 0;
    return e;
  endfunction

  function automatic fetch_t sample();
    return mk(icode, ifun, rA, rB, valC, valP, stat);
  endfunction

  // Instruction length table straight from the Y86-64 ISA
  function automatic int ref_len(logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:        return 1;
      4'h2, 4'h6, 4'hA, 4'hB:  return 2;
      4'h7, 4'h8:              return 9;
      4'h3, 4'h4, 4'h5:        return 10;
      default:                 return 1;
    endcase
  endfunction

  // Reference: walk the instruction bytes in memory and build the result
  function automatic fetch_t model(logic [63:0] p);
    fetch_t      e;
    int          len;
    bit          regs;
    logic [63:0] a;
    logic [7:0]  b;
    e = mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, p + 64'd1, 3'd1);
    if (p >= 64'(IMEM_SIZE)) begin e.stat = 3'd3; return e; end
    e.acks = 1;
    if (p == err_addr) begin e.stat = 3'd3; return e; end
    b = mem[p[11:0]];
    e.icode = b[7:4]; e.ifun = b[3:0];
    if (b[7:4] > 4'hB) begin e.stat = 3'd4; return e; end
    len    = ref_len(b[7:4]);
    e.valp = p + 64'(len);
    if (b[7:4] == 4'h0) begin e.stat = 3'd2; return e; end
    regs = (len == 2) || (len == 10);
    for (int i = 1; i < len; i++) begin
      a = p + 64'(i);
      if (a >= 64'(IMEM_SIZE)) begin e.stat = 3'd3; return e; end
      e.acks++;
      if (a == err_addr) begin e.stat = 3'd3; return e; end
      b = mem[a[11:0]];
      if (regs && i == 1) begin e.ra = b[7:4]; e.rb = b[3:0]; end
      else e.valc[8*(i - (regs ? 2 : 1)) +: 8] = b;
    end
    return e;
  endfunction

  task automatic load(input logic [63:0] p, input logic [79:0] bytes_le, input int n);
    for (int i = 0; i < n; i++) mem[p[11:0] + 12'(i)] = bytes_le[8*i +: 8];
  endtask

  // Start one fetch, wait for out_valid (bounded), optionally hold out_ready
  // low while checking the outputs stay frozen, then complete the handshake.
  // lat counts clock edges from the one that accepts start; -1 on timeout.
  task automatic run_fetch(input logic [63:0] p, input bit poke, input int hold,
                           output fetch_t obs, output int lat, output int frozen_bad);
    int a0;
    a0 = ack_count;
    frozen_bad = 0;
    start = 1'b1; pc = p;
    @(posedge clk); #1;
    start = 1'b0; pc = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 300) begin
      if (poke) begin start = 1'($urandom_range(1)); pc = {$urandom, $urandom}; end
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    obs = sample();
    for (int i = 0; i < hold; i++) begin
      if (poke) start = 1'($urandom_range(1));
      @(posedge clk); #1;
      if (pack(sample()) !== pack(obs) || !out_valid) frozen_bad++;
    end
    out_ready = 1'b1;
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    obs.acks = ack_count - a0;
  endtask

  task automatic test_reset();
    fetch_t r;
    r = mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1);
    checks++;
    if ({busy, mem_req, out_valid} !== 3'b000 || mem_addr !== 64'd0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/req/valid=%b%b%b mem_addr=%h, required 000 and 0",
               busy, mem_req, out_valid, mem_addr);
    end
    checks++;
    if (pack(sample()) !== pack(r)) begin
      errors++;
      $display("FAIL reset_fields: got %h required %h", pack(sample()), pack(r));
    end
    rst = 1'b0;
    @(posedge clk); #1;
    mem_auto = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'h30; mem_err = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_auto = 1'b1;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || pack(sample()) !== pack(r)) begin
      errors++;
      $display("FAIL idle_stale_ack: busy=%b req=%b fields=%h required idle with %h",
               busy, mem_req, pack(sample()), pack(r));
    end
  endtask

  task automatic test_irmovq();
    fetch_t o, e;
    int lat, fb;
    max_delay = 0;
    load(64'h100, 80'h01_23_45_67_89_AB_CD_EF_F3_30, 10);
    run_fetch(64'h100, 1'b0, 0, o, lat, fb);
    e = mk(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h10A, 3'd1);
    checks++;
    if (pack(o) !== pack(e)) begin
      errors++; $display("FAIL irmovq_fields: got %h required %h", pack(o), pack(e));
    end
    checks++;
    if (lat != 11 || o.acks != 10) begin
      errors++; $display("FAIL irmovq_timing: latency %0d acks %0d, required 11 and 10", lat, o.acks);
    end
  endtask

  task automatic test_jxx();
    fetch_t o, e;
    int lat, fb;
    load(64'h20, 80'h00_00_00_00_00_00_00_40_73, 9);
    run_fetch(64'h20, 1'b0, 0, o, lat, fb);
    e = mk(4'h7, 4'h3, 4'hF, 4'hF, 64'h40, 64'h29, 3'd1);
    checks++;
    if (pack(o) !== pack(e)) begin
      errors++; $display("FAIL jxx_fields: got %h required %h", pack(o), pack(e));
    end
    checks++;
    if (lat != 10 || o.acks != 9) begin
      errors++; $display("FAIL jxx_timing: latency %0d acks %0d, required 10 and 9", lat, o.acks);
    end
  endtask

  task automatic test_short();
    fetch_t o, e;
    int lat, fb;
    mem[0] = 8'h00; mem[12'h300] = 8'h90; mem[12'h400] = 8'hC0;
    run_fetch(64'h0, 1'b0, 0, o, lat, fb);
    e = mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 3'd2);
    checks++;
    if (pack(o) !== pack(e) || lat != 2 || o.acks != 1) begin
      errors++;
      $display("FAIL halt: got %h lat %0d acks %0d, required %h lat 2 acks 1", pack(o), lat, o.acks, pack(e));
    end
    run_fetch(64'h300, 1'b0, 0, o, lat, fb);
    e = mk(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'h301, 3'd1);
    checks++;
    if (pack(o) !== pack(e) || lat != 2) begin
      errors++; $display("FAIL ret: got %h lat %0d, required %h lat 2", pack(o), lat, pack(e));
    end
    run_fetch(64'h400, 1'b0, 0, o, lat, fb);
    e = mk(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'h401, 3'd4);
    checks++;
    if (pack(o) !== pack(e) || lat != 2 || o.acks != 1) begin
      errors++;
      $display("FAIL invalid_icode: got %h lat %0d acks %0d, required %h lat 2 acks 1", pack(o), lat, o.acks, pack(e));
    end
  endtask

  task automatic test_adr();
    fetch_t o, e;
    int lat, fb;
    load(64'(IMEM_SIZE - 2), 80'h00_00_00_00_00_00_00_00_F3_30, 2);
    run_fetch(64'(IMEM_SIZE - 2), 1'b0, 0, o, lat, fb);
    e = mk(4'h3, 4'h0, 4'hF, 4'h3, 64'd0, 64'(IMEM_SIZE + 8), 3'd3);
    checks++;
    if (pack(o) !== pack(e) || o.acks != 2 || lat != 4) begin
      errors++;
      $display("FAIL adr_edge: got %h acks %0d lat %0d, required %h acks 2 lat 4", pack(o), o.acks, lat, pack(e));
    end
    run_fetch(64'(IMEM_SIZE), 1'b0, 0, o, lat, fb);
    e = mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'(IMEM_SIZE + 1), 3'd3);
    checks++;
    if (pack(o) !== pack(e) || o.acks != 0 || lat != 2) begin
      errors++;
      $display("FAIL adr_first: got %h acks %0d lat %0d, required %h acks 0 lat 2", pack(o), o.acks, lat, pack(e));
    end
    load(64'h500, 80'h00_00_00_00_00_00_00_00_12_30, 2);
    err_addr = 64'h501;
    run_fetch(64'h500, 1'b0, 0, o, lat, fb);
    err_addr = '1;
    e = mk(4'h3, 4'h0, 4'hF, 4'hF, 64'd0, 64'h50A, 3'd3);
    checks++;
    if (pack(o) !== pack(e) || o.acks != 2) begin
      errors++; $display("FAIL mem_err: got %h acks %0d, required %h acks 2", pack(o), o.acks, pack(e));
    end
    checks++;
    if (bad_range != 0) begin
      errors++; $display("FAIL req_range: %0d out-of-range requests, required 0", bad_range);
    end
  endtask

  task automatic test_random();
    fetch_t o, e;
    int lat, fb;
    logic [63:0] p;
    max_delay = 5;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(3))
        0, 1:    p = 64'($urandom_range(IMEM_SIZE - 1));
        2:       p = 64'(IMEM_SIZE - 12) + 64'($urandom_range(14));
        default: p = {$urandom, $urandom} | 64'h1_0000;
      endcase
      for (int i = 0; i < 10; i++)
        if (p + 64'(i) < 64'(IMEM_SIZE)) mem[p[11:0] + 12'(i)] = 8'($urandom);
      err_addr = ($urandom_range(3) == 0) ? p + 64'($urandom_range(9)) : '1;
      e = model(p);
      run_fetch(p, 1'b1, 4, o, lat, fb);
      checks++;
      if (pack(o) !== pack(e)) begin
        errors++; $display("FAIL rand_fields[%0d] pc=%h: got %h required %h", it, p, pack(o), pack(e));
      end
      checks++;
      if (o.acks != e.acks) begin
        errors++; $display("FAIL rand_acks[%0d]: got %0d required %0d", it, o.acks, e.acks);
      end
      checks++;
      if (lat < 0) begin
        errors++; $display("FAIL rand_timeout[%0d]: out_valid never rose, required within 300 cycles", it);
      end
      checks++;
      if (fb != 0) begin
        errors++; $display("FAIL rand_frozen[%0d]: %0d cycles changed while stalled, required 0", it, fb);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL rand_idle[%0d]: busy=%b after handshake, required 0", it, busy);
      end
    end
    err_addr  = '1;
    max_delay = 0;
    checks++;
    if (bad_hold != 0 || bad_range != 0) begin
      errors++;
      $display("FAIL addr_stable: %0d changes under req, %0d out-of-range reqs, required 0 and 0", bad_hold, bad_range);
    end
  endtask

  task automatic test_reset_mid();
    fetch_t o, e, r;
    int lat, fb;
    r = mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1);
    load(64'h100, 80'h01_23_45_67_89_AB_CD_EF_F3_30, 10);
    start = 1'b1; pc = 64'h100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, mem_req, out_valid} !== 3'b000 || mem_addr !== 64'd0 || pack(sample()) !== pack(r)) begin
      errors++;
      $display("FAIL mid_reset: busy/req/valid=%b%b%b addr=%h fields=%h, required 000 0 %h",
               busy, mem_req, out_valid, mem_addr, pack(sample()), pack(r));
    end
    rst = 1'b0;
    mem_auto = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'h55; mem_err = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_auto = 1'b1;
    checks++;
    if (busy !== 1'b0 || pack(sample()) !== pack(r)) begin
      errors++; $display("FAIL late_ack: busy=%b fields=%h, required 0 %h", busy, pack(sample()), pack(r));
    end
    run_fetch(64'h100, 1'b0, 0, o, lat, fb);
    e = mk(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h10A, 3'd1);
    checks++;
    if (pack(o) !== pack(e) || lat != 11) begin
      errors++; $display("FAIL refetch: got %h lat %0d, required %h lat 11", pack(o), lat, pack(e));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pc = '0; out_ready = 1'b0;
    for (int i = 0; i < IMEM_SIZE; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_irmovq();
    test_jxx();
    test_short();
    test_adr();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
